// File: rtl/ast_req_queue_pkg.sv
// rtl/ast_req_queue_pkg.sv - shared constants for the scheduler request queues
package ast_req_queue_pkg;

    localparam int AST_DATA_WIDTH = 132;
    localparam int AST_RQ_DEPTH   = 8;

    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

    localparam int AST_RQ_PTR_W = ptr_width(AST_RQ_DEPTH);

endpackage

// File: rtl/ast_req_queue_if.sv
// rtl/ast_req_queue_if.sv - push side, scheduler leaf side and status of one request queue
interface ast_req_queue_if #(
    parameter int data_width  = 132,
    parameter int count_width = 4
);
    logic                   push_valid;
    logic                   push_ready;
    logic [data_width-1:0]  push_data;
    logic                   req;
    logic [data_width-1:0]  d_OUT;
    logic                   serv;
    logic [count_width-1:0] count;
    logic                   starve;
    logic                   err_spurious;

    modport master (
        output push_valid, push_data, serv,
        input  push_ready, req, d_OUT, count, starve, err_spurious
    );

    modport slave (
        input  push_valid, push_data, serv,
        output push_ready, req, d_OUT, count, starve, err_spurious
    );
endinterface

// File: rtl/ast_rq_mem.sv
// rtl/ast_rq_mem.sv - queue payload storage, synchronous write, asynchronous read
module ast_rq_mem #(
    parameter int data_width = 132,
    parameter int depth      = 8,
    parameter int addr_width = 3
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [addr_width-1:0] waddr,
    input  logic [data_width-1:0] wdata,
    input  logic [addr_width-1:0] raddr,
    output logic [data_width-1:0] rdata
);
    logic [data_width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/ast_req_queue.sv
// rtl/ast_req_queue.sv - in-order request buffer feeding one scheduler leaf, with starvation tracking
module ast_req_queue
    import ast_req_queue_pkg::*;
#(
    parameter int data_width   = AST_DATA_WIDTH,
    parameter int depth        = 8,
    parameter int starve_limit = 64,
    parameter int cnt_width    = 7
) (
    input logic           clk,
    input logic           rst,
    ast_req_queue_if.slave q
);
    localparam int pw = ptr_width(depth);
    localparam int cw = pw + 1;

    logic [pw-1:0]        rd_ptr;
    logic [pw-1:0]        wr_ptr;
    logic [cw-1:0]        occ;
    logic [cnt_width-1:0] wait_cnt;
    logic                 err_q;
    logic                 push;
    logic                 pop;

    assign q.push_ready   = occ != cw'(depth);
    assign q.req          = occ != '0;
    assign q.count        = occ;
    assign q.starve       = wait_cnt == cnt_width'(starve_limit);
    assign q.err_spurious = err_q;

    assign push = q.push_valid && q.push_ready;
    assign pop  = q.serv && q.req;

    // depth is a power of two, so the pointers wrap by plain overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            occ      <= '0;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                occ <= occ + 1'b1;
            end else if (pop && !push) begin
                occ <= occ - 1'b1;
            end
            if (!q.req || pop) begin
                wait_cnt <= '0;
            end else if (wait_cnt != cnt_width'(starve_limit)) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (q.serv && !q.req) begin
                err_q <= 1'b1;
            end
        end
    end

    ast_rq_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (pw)
    ) u_mem (
        .clk   (clk),
        .we    (push && !rst),
        .waddr (wr_ptr),
        .wdata (q.push_data),
        .raddr (rd_ptr),
        .rdata (q.d_OUT)
    );
endmodule

// File: tb/tb_ast_req_queue.sv
// tb/tb_ast_req_queue.sv - randomized and directed bench for ast_req_queue against a queue model
module tb_ast_req_queue;
    localparam int DW    = 132;
    localparam int DEPTH = 8;
    localparam int LIMIT = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_pass = 0;

    always #5 clk = ~clk;

    ast_req_queue_if #(.data_width(DW), .count_width(4)) bus ();

    ast_req_queue #(
        .data_width   (DW),
        .depth        (DEPTH),
        .starve_limit (LIMIT),
        .cnt_width    (7)
    ) dut (
        .clk (clk),
        .rst (rst),
        .q   (bus)
    );

    logic [DW-1:0] m_q [$];
    int            m_wait = 0;
    bit            m_err  = 1'b0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("count", bus.count, m_q.size());
        chk("req", bus.req, m_q.size() != 0);
        chk("push_ready", bus.push_ready, m_q.size() != DEPTH);
        chk("starve", bus.starve, m_wait == LIMIT);
        chk("err_spurious", bus.err_spurious, m_err);
        if (m_q.size() != 0) begin
            chk("d_OUT", bus.d_OUT, m_q[0]);
        end
    endtask

    // One cycle: drive, compare at the falling edge, then advance the model with the DUT.
    task automatic step(input logic pv, input logic [DW-1:0] pd, input logic sv, input logic r);
        int  sz;
        bit  acc;
        bit  popped;
        rst            = r;
        bus.push_valid = pv;
        bus.push_data  = pd;
        bus.serv       = sv;
        @(negedge clk);
        check_model();
        @(posedge clk);
        sz = m_q.size();
        if (r) begin
            m_q.delete();
            m_wait = 0;
            m_err  = 1'b0;
        end else begin
            acc    = pv && (sz < DEPTH);
            popped = sv && (sz > 0);
            if (sv && sz == 0) m_err = 1'b1;
            if (sz == 0 || popped) m_wait = 0;
            else if (m_wait < LIMIT) m_wait = m_wait + 1;
            if (popped) void'(m_q.pop_front());
            if (acc) m_q.push_back(pd);
        end
        #1;
    endtask

    function automatic logic [DW-1:0] rnd_data();
        return {$urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        bus.push_valid = 1'b0;
        bus.push_data  = '0;
        bus.serv       = 1'b0;

        // reset state and first-push latency
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("rst_count", bus.count, 0);
        chk("rst_req", bus.req, 0);
        chk("rst_ready", bus.push_ready, 1);
        chk("rst_starve", bus.starve, 0);
        chk("rst_err", bus.err_spurious, 0);
        step(1, 'hA, 0, 0);
        chk("lat_req", bus.req, 1);
        chk("lat_dout", bus.d_OUT, 'hA);
        step(1, 'hB, 0, 0);
        step(1, 'hC, 0, 0);
        chk("abc_count", bus.count, 3);
        chk("abc_dout", bus.d_OUT, 'hA);
        chk("abc_ready", bus.push_ready, 1);

        // full, held push, single pop, late acceptance
        step(0, 0, 0, 1);
        for (int i = 0; i < DEPTH; i++) step(1, DW'(i), 0, 0);
        for (int i = 0; i < 3; i++) step(1, 'h99, 0, 0);
        chk("full_ready", bus.push_ready, 0);
        chk("full_count", bus.count, 8);
        step(1, 'h99, 1, 0);
        chk("pop_dout", bus.d_OUT, 1);
        chk("pop_count", bus.count, 7);
        chk("pop_ready", bus.push_ready, 1);
        step(1, 'h99, 0, 0);
        chk("refill_count", bus.count, 8);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, 0);
        chk("drained", bus.count, 0);

        // steady push+pop with wrap
        for (int i = 0; i < 4; i++) step(1, rnd_data(), 0, 0);
        for (int i = 0; i < 20; i++) step(1, rnd_data(), 1, 0);
        chk("pp_count", bus.count, 4);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // starvation threshold
        step(1, 'h5A, 0, 0);
        for (int i = 0; i < LIMIT - 1; i++) step(0, 0, 0, 0);
        chk("starve_before", bus.starve, 0);
        step(0, 0, 0, 0);
        chk("starve_at", bus.starve, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        chk("starve_hold", bus.starve, 1);
        step(0, 0, 1, 0);
        chk("starve_clear", bus.starve, 0);
        chk("starve_count", bus.count, 0);

        // spurious grant
        step(0, 0, 1, 0);
        chk("spur_err", bus.err_spurious, 1);
        chk("spur_count", bus.count, 0);
        chk("spur_req", bus.req, 0);
        for (int i = 0; i < 6; i++) step(1, rnd_data(), i[0], 0);
        chk("spur_sticky", bus.err_spurious, 1);

        // reset mid-traffic with push and serv
        step(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(1, rnd_data(), 0, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 0, 0);
        step(0, 0, 1, 0);
        step(1, rnd_data(), 1, 1);
        chk("mrst_count", bus.count, 0);
        chk("mrst_req", bus.req, 0);
        chk("mrst_ready", bus.push_ready, 1);
        chk("mrst_starve", bus.starve, 0);
        chk("mrst_err", bus.err_spurious, 0);

        // randomized traffic with occasional long stalls and resets
        for (int i = 0; i < 3000; i++) begin
            int ph;
            ph = (i / 250) % 3;
            step($urandom_range(0, 3) != 0,
                 rnd_data(),
                 (ph == 2) ? 1'b0 : ($urandom_range(0, ph == 0 ? 1 : 3) == 0),
                 $urandom_range(0, 399) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/ast_req_queue.md
Name: ast_req_queue

Overview:
Per-requester request buffer that sits directly upstream of one leaf input of the access scheduler tree. It accepts access requests from a core or interconnect port and holds them in order. It presents the head entry to the tree as a level request with its payload, and retires that entry when the tree grants service. It also tracks how long the head entry has waited and raises a starvation flag for the interconnect monitor.

Parameters:
data_width, 132, request payload width (opaque; matches scheduler tree data_width)
depth, 8, queue entries; power of two, minimum 2
starve_limit, 64, cycles the head may wait ungranted before starve asserts; minimum 1
cnt_width, 7, starvation counter width; must satisfy 2^cnt_width > starve_limit

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  reset; synchronous, active-high
push_valid  in  1  upstream offers a request this cycle
push_ready  out  1  queue can accept; high iff not full
push_data  in  data_width  request payload
req  out  1  to scheduler leaf req; high iff queue not empty
d_OUT  out  data_width  head payload to scheduler leaf data input
serv  in  1  grant from scheduler for this leaf (combinational AND of its path serv bits)
count  out  log2(depth)+1  number of occupied entries
starve  out  1  head has waited >= starve_limit cycles
err_spurious  out  1  sticky: serv seen while req low

Behaviour:
- Reset (rst high at posedge) clears the read and write pointers, count=0, starvation counter=0 and err_spurious=0. Payload storage is not cleared.
- Outputs after reset: push_ready=1, req=0, starve=0, count=0, err_spurious=0. d_OUT is don't-care while req=0.
- A reset asserted mid-operation discards all entries at that edge. A push or serv in the same cycle is ignored.
- Push happens when push_valid && push_ready: payload is written at the write pointer, and the write pointer advances modulo depth.
- Pop happens when serv && req: the read pointer advances modulo depth.
- count updates every cycle as +1 for push only, -1 for pop only, and unchanged for both or neither.
- req and push_ready are derived from registered count (req = count != 0; push_ready = count != depth). Neither output depends combinationally on push_valid or serv.
- d_OUT is read from storage at the read pointer; it is combinational from registered pointers and storage.
- Latency: a push into an empty queue gives req=1 and d_OUT=that payload on the following cycle. There is no same-cycle bypass.
- Full: push_ready=0 and push_valid is ignored, even if serv pops in the same cycle. No fall-through; push_ready rises the cycle after the pop.
- Empty: req=0. serv is ignored for state, but sets err_spurious, which stays set until rst.
- Simultaneous push and pop with 0 < count < depth: both happen and count is unchanged. Pointer wrap-around is seamless.
- Head ordering is strict FIFO. The entry presented on d_OUT is the entry retired on serv.
- Starvation counter:
  - Clears on rst, on any pop, and in any cycle with req=0.
  - Otherwise increments by 1 each cycle that req=1 and serv=0, saturating at starve_limit.
  - starve = (counter == starve_limit) and is a registered output.
  - It deasserts the cycle after the head is popped, unless the queue is then empty. In that case it deasserts anyway, because the counter cleared.
  - A new head after a pop starts counting from 0.
- The block never drops or duplicates an accepted entry. Pushes while full are flow-controlled, not lost.

Decomposition:
- Shared package: AST_DATA_WIDTH=132 (used by this block and the scheduler tree) and a helper constant for the pointer width log2(depth).
- One sub-module, ast_rq_mem: depth x data_width storage with one synchronous write port and one asynchronous read port (write enable, write address, write data, read address, read data). It has no reset.
- Pointer, count and starvation logic stays in ast_req_queue.

Test Plan:
- Reset, then push 0xA, 0xB, 0xC on consecutive cycles with serv=0 -> req rises the cycle after the 0xA push; d_OUT=0xA; count=3; push_ready=1.
- Fill to depth 8 with 0..7, then hold push_valid=1 with payload 0x99 -> push_ready=0 and count stays 8. Pulse serv once -> d_OUT=1 next cycle, count=7, push_ready=1. 0x99 is accepted only after push_ready returns high.
- With 4 entries, assert push_valid and serv together for 20 cycles -> count stays 4; the pointers wrap; the popped sequence matches the push order exactly.
- Hold 1 entry with serv=0 for 64 cycles -> starve=1 from the 65th cycle after req rose, and remains 1 while waiting. Pulse serv -> starve=0 the next cycle; count=0.
- In the empty state, pulse serv=1 -> count stays 0, req=0 and err_spurious=1. err_spurious stays 1 through later traffic until rst.
- With 5 entries and starve counting, assert rst together with push_valid and serv -> the next cycle has count=0, req=0, push_ready=1, starve=0, err_spurious=0.
